// File: rtl/id_ex_operand_stage_if.sv
// ID -> EX operand-stage bus: decoded ID fields and regfile/writeback data in, registered EX slot out.
// master drives the ID side; slave is the operand stage itself.
interface id_ex_operand_stage_if #(
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [4:0]        id_rs_addr;
  logic [4:0]        id_rt_addr;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [31:0]       rs_data;
  logic [31:0]       rt_data;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [4:0]        id_dst_addr;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              wb_reg_write;
  logic [4:0]        wb_addr;
  logic [31:0]       wb_data;
  logic              stall_in;
  logic              flush;
  logic              ex_valid;
  logic [31:0]       ex_rs_val;
  logic [31:0]       ex_rt_val;
  logic [31:0]       ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [4:0]        ex_rs_addr;
  logic [4:0]        ex_rt_addr;
  logic [4:0]        ex_dst_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              load_use_stall;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, rs_data, rt_data,
           id_imm, id_ctrl, id_dst_addr, id_reg_write, id_mem_read,
           wb_reg_write, wb_addr, wb_data, stall_in, flush,
    input  ex_valid, ex_rs_val, ex_rt_val, ex_imm, ex_ctrl, ex_rs_addr, ex_rt_addr,
           ex_dst_addr, ex_reg_write, ex_mem_read, load_use_stall, bubble_cnt
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, rs_data, rt_data,
           id_imm, id_ctrl, id_dst_addr, id_reg_write, id_mem_read,
           wb_reg_write, wb_addr, wb_data, stall_in, flush,
    output ex_valid, ex_rs_val, ex_rt_val, ex_imm, ex_ctrl, ex_rs_addr, ex_rt_addr,
           ex_dst_addr, ex_reg_write, ex_mem_read, load_use_stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: resolves $0 / writeback bypass, inserts load-use bubbles, applies stall/flush.
// Optional same-cycle writeback bypass enabled by defining WB_BYPASS_EN.
module id_ex_operand_stage #(
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  id_ex_operand_stage_if.slave bus
);
  logic [31:0]       rsRes, rtRes;
  logic              hz;
  logic              exValid, exRegWrite, exMemRead;
  logic [31:0]       exRsVal, exRtVal, exImm;
  logic [CTRL_W-1:0] exCtrl;
  logic [4:0]        exRsAddr, exRtAddr, exDstAddr;
  logic [CNT_W-1:0]  bubbleCnt;

  always_comb begin
    rsRes = bus.rs_data;
    rtRes = bus.rt_data;
`ifdef WB_BYPASS_EN
    // Regfile async read returns the pre-write value during the write cycle.
    if (bus.wb_reg_write && bus.wb_addr != 5'd0 && bus.wb_addr == bus.id_rs_addr) rsRes = bus.wb_data;
    if (bus.wb_reg_write && bus.wb_addr != 5'd0 && bus.wb_addr == bus.id_rt_addr) rtRes = bus.wb_data;
`endif
    if (bus.id_rs_addr == 5'd0) rsRes = '0;
    if (bus.id_rt_addr == 5'd0) rtRes = '0;
  end

  always_comb begin
    hz = bus.id_valid && exValid && exMemRead && exRegWrite && (exDstAddr != 5'd0) &&
         ((bus.id_uses_rs && exDstAddr == bus.id_rs_addr) ||
          (bus.id_uses_rt && exDstAddr == bus.id_rt_addr));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exValid    <= 1'b0;
      exRegWrite <= 1'b0;
      exMemRead  <= 1'b0;
      exRsVal    <= '0;
      exRtVal    <= '0;
      exImm      <= '0;
      exCtrl     <= '0;
      exRsAddr   <= '0;
      exRtAddr   <= '0;
      exDstAddr  <= '0;
      bubbleCnt  <= '0;
    end else if (bus.flush) begin
      exValid    <= 1'b0;
      exRegWrite <= 1'b0;
      exMemRead  <= 1'b0;
      exRsVal    <= '0;
      exRtVal    <= '0;
      exImm      <= '0;
      exCtrl     <= '0;
      exRsAddr   <= '0;
      exRtAddr   <= '0;
      exDstAddr  <= '0;
    end else if (!bus.stall_in) begin
      if (hz) begin
        exValid    <= 1'b0;
        exRegWrite <= 1'b0;
        exMemRead  <= 1'b0;
        exCtrl     <= '0;
        if (bubbleCnt != '1) bubbleCnt <= bubbleCnt + CNT_W'(1);
      end else begin
        exValid    <= bus.id_valid;
        exRegWrite <= bus.id_reg_write & bus.id_valid;
        exMemRead  <= bus.id_mem_read & bus.id_valid;
        exRsVal    <= rsRes;
        exRtVal    <= rtRes;
        exImm      <= bus.id_imm;
        exCtrl     <= bus.id_ctrl;
        exRsAddr   <= bus.id_rs_addr;
        exRtAddr   <= bus.id_rt_addr;
        exDstAddr  <= bus.id_dst_addr;
      end
    end
  end

  assign bus.ex_valid       = exValid;
  assign bus.ex_rs_val      = exRsVal;
  assign bus.ex_rt_val      = exRtVal;
  assign bus.ex_imm         = exImm;
  assign bus.ex_ctrl        = exCtrl;
  assign bus.ex_rs_addr     = exRsAddr;
  assign bus.ex_rt_addr     = exRtAddr;
  assign bus.ex_dst_addr    = exDstAddr;
  assign bus.ex_reg_write   = exRegWrite;
  assign bus.ex_mem_read    = exMemRead;
  assign bus.load_use_stall = hz;
  assign bus.bubble_cnt     = bubbleCnt;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: default-width instance plus a CNT_W=2 instance for saturation.
// Both instances see identical ID-side stimulus.
module tb_id_ex_operand_stage;
  logic        clk = 1'b0;
  logic        rstN;
  logic        idValid, idUsesRs, idUsesRt, idRegWrite, idMemRead;
  logic [4:0]  idRsAddr, idRtAddr, idDstAddr, wbAddr;
  logic [31:0] rsData, rtData, idImm, wbData;
  logic [11:0] idCtrl;
  logic        wbRegWrite, stallIn, flush;
  logic [31:0] expRt;
  int unsigned nVec = 0;
  int unsigned nErr = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.CTRL_W(12), .CNT_W(16)) b0 ();
  id_ex_operand_stage_if #(.CTRL_W(12), .CNT_W(2))  b1 ();

  id_ex_operand_stage #(.CTRL_W(12), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rstN), .bus(b0.slave));
  id_ex_operand_stage #(.CTRL_W(12), .CNT_W(2))  dut1 (.clk(clk), .rst_n(rstN), .bus(b1.slave));

  assign b0.id_valid = idValid;     assign b1.id_valid = idValid;
  assign b0.id_rs_addr = idRsAddr;  assign b1.id_rs_addr = idRsAddr;
  assign b0.id_rt_addr = idRtAddr;  assign b1.id_rt_addr = idRtAddr;
  assign b0.id_uses_rs = idUsesRs;  assign b1.id_uses_rs = idUsesRs;
  assign b0.id_uses_rt = idUsesRt;  assign b1.id_uses_rt = idUsesRt;
  assign b0.rs_data = rsData;       assign b1.rs_data = rsData;
  assign b0.rt_data = rtData;       assign b1.rt_data = rtData;
  assign b0.id_imm = idImm;         assign b1.id_imm = idImm;
  assign b0.id_ctrl = idCtrl;       assign b1.id_ctrl = idCtrl;
  assign b0.id_dst_addr = idDstAddr; assign b1.id_dst_addr = idDstAddr;
  assign b0.id_reg_write = idRegWrite; assign b1.id_reg_write = idRegWrite;
  assign b0.id_mem_read = idMemRead; assign b1.id_mem_read = idMemRead;
  assign b0.wb_reg_write = wbRegWrite; assign b1.wb_reg_write = wbRegWrite;
  assign b0.wb_addr = wbAddr;       assign b1.wb_addr = wbAddr;
  assign b0.wb_data = wbData;       assign b1.wb_data = wbData;
  assign b0.stall_in = stallIn;     assign b1.stall_in = stallIn;
  assign b0.flush = flush;          assign b1.flush = flush;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    idValid = 0; idUsesRs = 0; idUsesRt = 0; idRegWrite = 0; idMemRead = 0;
    idRsAddr = 0; idRtAddr = 0; idDstAddr = 0; rsData = 0; rtData = 0;
    idImm = 0; idCtrl = 0; wbRegWrite = 0; wbAddr = 0; wbData = 0;
    stallIn = 0; flush = 0;
  endtask

  // Plain ALU op in ID: reads rs and rt, writes dst.
  task automatic setAlu(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                        input logic [31:0] rtd, input logic [4:0] dst);
    idValid = 1; idUsesRs = 1; idUsesRt = 1; idRegWrite = 1; idMemRead = 0;
    idRsAddr = rs; rsData = rsd; idRtAddr = rt; rtData = rtd; idDstAddr = dst;
  endtask

  task automatic setLoad(input logic [4:0] dst);
    idValid = 1; idUsesRs = 1; idUsesRt = 0; idRegWrite = 1; idMemRead = 1;
    idRsAddr = 5'd29; rsData = 32'h1000; idRtAddr = dst; rtData = 0; idDstAddr = dst;
  endtask

  task automatic test_reset();
    setIdle();
    rstN = 0;
    setAlu(5'd3, 32'h33, 5'd4, 32'h44, 5'd7);
    idImm = 32'h55; idCtrl = 12'hFFF;
    tick(); tick();
    nVec++; if (b0.ex_valid !== 1'b0) begin nErr++; $display("FAIL rst_valid got %0h want 0", b0.ex_valid); end
    nVec++; if (b0.ex_rs_val !== 32'h0) begin nErr++; $display("FAIL rst_rs_val got %0h want 0", b0.ex_rs_val); end
    nVec++; if (b0.ex_ctrl !== 12'h0) begin nErr++; $display("FAIL rst_ctrl got %0h want 0", b0.ex_ctrl); end
    nVec++; if (b0.ex_dst_addr !== 5'h0) begin nErr++; $display("FAIL rst_dst got %0h want 0", b0.ex_dst_addr); end
    nVec++; if (b0.ex_reg_write !== 1'b0) begin nErr++; $display("FAIL rst_rw got %0h want 0", b0.ex_reg_write); end
    nVec++; if (b0.bubble_cnt !== 16'h0) begin nErr++; $display("FAIL rst_bcnt got %0h want 0", b0.bubble_cnt); end
    nVec++; if (b0.load_use_stall !== 1'b0) begin nErr++; $display("FAIL rst_lus got %0h want 0", b0.load_use_stall); end
    rstN = 1;
  endtask

  task automatic test_zero_reg();
    setIdle();
    setAlu(5'd0, 32'hDEAD_BEEF, 5'd3, 32'h0000_0033, 5'd4);
    idImm = 32'h0000_1111; idCtrl = 12'hABC;
    tick();
    nVec++; if (b0.ex_valid !== 1'b1) begin nErr++; $display("FAIL z_valid got %0h want 1", b0.ex_valid); end
    nVec++; if (b0.ex_rs_val !== 32'h0) begin nErr++; $display("FAIL z_rs_val got %0h want 0", b0.ex_rs_val); end
    nVec++; if (b0.ex_rt_val !== 32'h33) begin nErr++; $display("FAIL z_rt_val got %0h want 33", b0.ex_rt_val); end
    nVec++; if (b0.ex_imm !== 32'h1111) begin nErr++; $display("FAIL z_imm got %0h want 1111", b0.ex_imm); end
    nVec++; if (b0.ex_ctrl !== 12'hABC) begin nErr++; $display("FAIL z_ctrl got %0h want abc", b0.ex_ctrl); end
    nVec++; if (b0.ex_rt_addr !== 5'd3) begin nErr++; $display("FAIL z_rt_addr got %0d want 3", b0.ex_rt_addr); end
    nVec++; if (b0.ex_dst_addr !== 5'd4) begin nErr++; $display("FAIL z_dst got %0d want 4", b0.ex_dst_addr); end
    nVec++; if (b0.ex_reg_write !== 1'b1) begin nErr++; $display("FAIL z_rw got %0h want 1", b0.ex_reg_write); end
    nVec++; if (b0.ex_mem_read !== 1'b0) begin nErr++; $display("FAIL z_mr got %0h want 0", b0.ex_mem_read); end
  endtask

  task automatic test_wb_bypass();
    setIdle();
    setAlu(5'd6, 32'h66, 5'd5, 32'h0, 5'd9);
    wbRegWrite = 1; wbAddr = 5'd5; wbData = 32'h1234_5678;
`ifdef WB_BYPASS_EN
    expRt = 32'h1234_5678;
`else
    expRt = 32'h0;
`endif
    tick();
    nVec++; if (b0.ex_rt_val !== expRt) begin nErr++; $display("FAIL wb_rt_val got %0h want %0h", b0.ex_rt_val, expRt); end
    nVec++; if (b0.ex_rs_val !== 32'h66) begin nErr++; $display("FAIL wb_rs_other got %0h want 66", b0.ex_rs_val); end
    // $0 stays zero even when WB targets it.
    setAlu(5'd0, 32'h77, 5'd0, 32'h88, 5'd9);
    wbAddr = 5'd0; wbData = 32'hFFFF_FFFF;
    tick();
    nVec++; if (b0.ex_rs_val !== 32'h0) begin nErr++; $display("FAIL wb_zero_rs got %0h want 0", b0.ex_rs_val); end
    // Write disabled: regfile data passes through.
    setAlu(5'd5, 32'hAA, 5'd5, 32'hBB, 5'd9);
    wbRegWrite = 0; wbAddr = 5'd5; wbData = 32'h1234_5678;
    tick();
    nVec++; if (b0.ex_rt_val !== 32'hBB) begin nErr++; $display("FAIL wb_nowrite got %0h want bb", b0.ex_rt_val); end
  endtask

  task automatic test_back_to_back();
    setIdle();
    setAlu(5'd1, 32'h11, 5'd2, 32'h22, 5'd3);
    idImm = 32'hA;
    tick();
    setAlu(5'd4, 32'h44, 5'd5, 32'h55, 5'd6);
    idImm = 32'hB;
    nVec++; if (b0.ex_rs_val !== 32'h11) begin nErr++; $display("FAIL b2b_first got %0h want 11", b0.ex_rs_val); end
    tick();
    nVec++; if (b0.ex_rs_val !== 32'h44) begin nErr++; $display("FAIL b2b_second got %0h want 44", b0.ex_rs_val); end
    nVec++; if (b0.ex_imm !== 32'hB) begin nErr++; $display("FAIL b2b_imm got %0h want b", b0.ex_imm); end
    // Invalid ID slot: write/load flags qualified off.
    idValid = 0; idMemRead = 1; idRegWrite = 1;
    tick();
    nVec++; if (b0.ex_valid !== 1'b0) begin nErr++; $display("FAIL inv_valid got %0h want 0", b0.ex_valid); end
    nVec++; if (b0.ex_reg_write !== 1'b0) begin nErr++; $display("FAIL inv_rw got %0h want 0", b0.ex_reg_write); end
    nVec++; if (b0.ex_mem_read !== 1'b0) begin nErr++; $display("FAIL inv_mr got %0h want 0", b0.ex_mem_read); end
  endtask

  task automatic test_load_use();
    setIdle();
    setLoad(5'd8);
    tick();
    nVec++; if (b0.ex_mem_read !== 1'b1) begin nErr++; $display("FAIL lu_load_mr got %0h want 1", b0.ex_mem_read); end
    setAlu(5'd8, 32'h80, 5'd2, 32'h22, 5'd10);
    idCtrl = 12'h123;
    #1;
    nVec++; if (b0.load_use_stall !== 1'b1) begin nErr++; $display("FAIL lu_stall got %0h want 1", b0.load_use_stall); end
    tick();
    nVec++; if (b0.ex_valid !== 1'b0) begin nErr++; $display("FAIL lu_bubble_valid got %0h want 0", b0.ex_valid); end
    nVec++; if (b0.ex_ctrl !== 12'h0) begin nErr++; $display("FAIL lu_bubble_ctrl got %0h want 0", b0.ex_ctrl); end
    nVec++; if (b0.bubble_cnt !== 16'd1) begin nErr++; $display("FAIL lu_bcnt got %0d want 1", b0.bubble_cnt); end
    nVec++; if (b0.load_use_stall !== 1'b0) begin nErr++; $display("FAIL lu_stall_drop got %0h want 0", b0.load_use_stall); end
    tick();
    nVec++; if (b0.ex_valid !== 1'b1) begin nErr++; $display("FAIL lu_add_valid got %0h want 1", b0.ex_valid); end
    nVec++; if (b0.ex_rs_val !== 32'h80) begin nErr++; $display("FAIL lu_add_rs got %0h want 80", b0.ex_rs_val); end
    nVec++; if (b0.ex_dst_addr !== 5'd10) begin nErr++; $display("FAIL lu_add_dst got %0d want 10", b0.ex_dst_addr); end
    // Dependent via rt but rt unused: no hazard.
    setLoad(5'd12);
    tick();
    setAlu(5'd1, 32'h1, 5'd12, 32'h2, 5'd13);
    idUsesRt = 0;
    #1;
    nVec++; if (b0.load_use_stall !== 1'b0) begin nErr++; $display("FAIL lu_unused_rt got %0h want 0", b0.load_use_stall); end
    // Load into $0 never stalls.
    tick();
    setLoad(5'd0);
    tick();
    setAlu(5'd0, 32'h0, 5'd0, 32'h0, 5'd13);
    #1;
    nVec++; if (b0.load_use_stall !== 1'b0) begin nErr++; $display("FAIL lu_zero_dst got %0h want 0", b0.load_use_stall); end
    tick();
    nVec++; if (b0.bubble_cnt !== 16'd1) begin nErr++; $display("FAIL lu_bcnt_after got %0d want 1", b0.bubble_cnt); end
  endtask

  task automatic test_flush_stall();
    setIdle();
    setLoad(5'd8);
    idImm = 32'hCAFE; idCtrl = 12'h5A5;
    tick();
    // Stall with a dependent op in ID: hold everything, no bubble counted.
    setAlu(5'd8, 32'h99, 5'd8, 32'h98, 5'd11);
    idImm = 32'h1; idCtrl = 12'h1;
    stallIn = 1;
    tick();
    nVec++; if (b0.ex_valid !== 1'b1) begin nErr++; $display("FAIL st_valid got %0h want 1", b0.ex_valid); end
    nVec++; if (b0.ex_imm !== 32'hCAFE) begin nErr++; $display("FAIL st_imm got %0h want cafe", b0.ex_imm); end
    nVec++; if (b0.ex_ctrl !== 12'h5A5) begin nErr++; $display("FAIL st_ctrl got %0h want 5a5", b0.ex_ctrl); end
    nVec++; if (b0.ex_dst_addr !== 5'd8) begin nErr++; $display("FAIL st_dst got %0d want 8", b0.ex_dst_addr); end
    nVec++; if (b0.ex_mem_read !== 1'b1) begin nErr++; $display("FAIL st_mr got %0h want 1", b0.ex_mem_read); end
    nVec++; if (b0.bubble_cnt !== 16'd1) begin nErr++; $display("FAIL st_bcnt got %0d want 1", b0.bubble_cnt); end
    flush = 1;
    tick();
    nVec++; if (b0.ex_valid !== 1'b0) begin nErr++; $display("FAIL fl_valid got %0h want 0", b0.ex_valid); end
    nVec++; if (b0.ex_imm !== 32'h0) begin nErr++; $display("FAIL fl_imm got %0h want 0", b0.ex_imm); end
    nVec++; if (b0.ex_mem_read !== 1'b0) begin nErr++; $display("FAIL fl_mr got %0h want 0", b0.ex_mem_read); end
    nVec++; if (b0.ex_dst_addr !== 5'd0) begin nErr++; $display("FAIL fl_dst got %0d want 0", b0.ex_dst_addr); end
    nVec++; if (b0.bubble_cnt !== 16'd1) begin nErr++; $display("FAIL fl_bcnt got %0d want 1", b0.bubble_cnt); end
    stallIn = 0; flush = 0;
  endtask

  task automatic test_saturate();
    // Four more load/dependent pairs: counters 1->5 and 1->3(sat), then one more.
    for (int i = 0; i < 5; i++) begin
      setIdle();
      setLoad(5'd8);
      tick();
      setAlu(5'd8, 32'h1, 5'd2, 32'h2, 5'd3);
      tick();
    end
    nVec++; if (b1.bubble_cnt !== 2'b11) begin nErr++; $display("FAIL sat_cnt2 got %0d want 3", b1.bubble_cnt); end
    nVec++; if (b0.bubble_cnt !== 16'd6) begin nErr++; $display("FAIL sat_cnt16 got %0d want 6", b0.bubble_cnt); end
  endtask

  task automatic test_reset_mid();
    setIdle();
    setAlu(5'd1, 32'h11, 5'd2, 32'h22, 5'd3);
    tick();
    rstN = 0; stallIn = 1; flush = 1;
    tick();
    nVec++; if (b0.ex_valid !== 1'b0) begin nErr++; $display("FAIL rm_valid got %0h want 0", b0.ex_valid); end
    nVec++; if (b0.ex_rs_val !== 32'h0) begin nErr++; $display("FAIL rm_rs got %0h want 0", b0.ex_rs_val); end
    nVec++; if (b0.bubble_cnt !== 16'd0) begin nErr++; $display("FAIL rm_bcnt got %0d want 0", b0.bubble_cnt); end
    nVec++; if (b1.bubble_cnt !== 2'd0) begin nErr++; $display("FAIL rm_bcnt2 got %0d want 0", b1.bubble_cnt); end
    rstN = 1; stallIn = 0; flush = 0; idValid = 0;
    tick();
    nVec++; if (b0.ex_valid !== 1'b0) begin nErr++; $display("FAIL rm_post got %0h want 0", b0.ex_valid); end
  endtask

  initial begin
    setIdle();
    rstN = 0;
    test_reset();
    test_zero_reg();
    test_wb_bypass();
    test_back_to_back();
    test_load_use();
    test_flush_stall();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
